// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: redirect from the PC stage, instruction-memory
// req/gnt/rvalid channel, and the valid/ready channel toward decode.
interface instr_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               redirect;
  logic [ADDR_W-1:0]  pc_in;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    input  redirect, pc_in, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, pc_in, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read at a time, a small
// prefetch queue toward decode, and flush/discard on PC redirect.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t             r_state;
  logic               r_imem_req;
  logic [ADDR_W-1:0]  r_fetch_ptr;
  logic [ADDR_W-1:0]  r_req_addr;

  logic [INSTR_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;

  logic               w_pop;
  logic               w_push;
  logic               w_bypass;
  logic               w_credit_idle;
  logic               w_credit_push;
  logic [PTR_W-1:0]   w_rd_ptr_next;
  logic [CNT_W-1:0]   w_count_kept;
  logic [CNT_W-1:0]   w_count_next;
  logic [INSTR_W-1:0] w_head_instr;
  logic [ADDR_W-1:0]  w_head_pc;

  // A response that races a redirect is never pushed; the queue is being cleared.
  always_comb begin
    w_pop         = r_instr_valid && bus.instr_ready;
    w_push        = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    w_count_kept  = r_count - CNT_W'(w_pop);
    w_count_next  = bus.redirect ? '0 : (w_count_kept + CNT_W'(w_push));
    w_bypass      = w_push && (w_count_kept == '0);
    w_credit_idle = r_count < FULL_CNT;
    w_credit_push = w_count_next < FULL_CNT;
    w_head_instr  = w_bypass ? bus.imem_rdata : r_mem_instr[w_rd_ptr_next];
    w_head_pc     = w_bypass ? r_req_addr     : r_mem_pc[w_rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_req_addr;
    end
  end

  // Head registers load the next head early so decode sees a registered value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_count       <= w_count_next;
      r_instr_valid <= (w_count_next != '0);
      if (bus.redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
        r_rd_ptr <= w_rd_ptr_next;
      end
      if (w_count_next != '0) begin
        r_instr    <= w_head_instr;
        r_instr_pc <= w_head_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_imem_req  <= 1'b0;
      r_fetch_ptr <= RESET_ADDR;
      r_req_addr  <= RESET_ADDR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.redirect) begin
            r_fetch_ptr <= bus.pc_in;
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
          end else if (w_credit_idle) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            r_req_addr <= r_fetch_ptr;
            r_imem_req <= 1'b0;
            if (bus.redirect) begin
              r_fetch_ptr <= bus.pc_in;
              r_state     <= S_DROP;
            end else begin
              r_fetch_ptr <= r_fetch_ptr + ADDR_W'(1);
              r_state     <= S_WAIT;
            end
          end else if (bus.redirect) begin
            r_fetch_ptr <= bus.pc_in;
          end
        end
        S_WAIT: begin
          if (bus.redirect) begin
            r_fetch_ptr <= bus.pc_in;
            if (bus.imem_rvalid) begin
              r_state    <= S_REQ;
              r_imem_req <= 1'b1;
            end else begin
              r_state <= S_DROP;
            end
          end else if (bus.imem_rvalid) begin
            if (w_credit_push) begin
              r_state    <= S_REQ;
              r_imem_req <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (bus.redirect) begin
            r_fetch_ptr <= bus.pc_in;
          end
          if (bus.imem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_fetch_ptr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, transaction-level scoreboard,
// redirect vector table, directed corner sequences and a randomized soak.
module tb_instr_fetch_unit;
  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) ifc ();

  instr_fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  typedef struct {
    logic [15:0] target;
    logic [15:0] exp_pc0;
    logic [15:0] exp_pc1;
    int          exp_lat;
  } vec_t;
  vec_t vecs [5];

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs
  bit          gnt_en;
  int          gnt_pct, rdy_pct, dly_min, dly_max;
  bit          drv_redirect, drv_rst;
  logic [15:0] drv_pc;

  // memory responder
  bit          rsp_pend, rsp_stale;
  logic [15:0] rsp_addr;
  int          rsp_dly;

  // reference model: next expected decode pc, next expected fetch address,
  // reads granted but not yet consumed since the last flush
  logic [15:0] exp_pc, exp_fetch;
  int          occ;
  int          npop, ngnt;
  logic [15:0] pop_pc_log[$];
  logic [15:0] pop_instr_log[$];
  logic [15:0] gnt_addr_log[$];

  logic        s_req, s_valid, s_rdy, s_gnt;
  logic [15:0] s_addr, s_instr, s_pc;
  logic        p_req, p_gnt, p_redirect, p_rst;
  logic [15:0] p_addr, p_pc_in;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic rv;
    @(negedge clk);
    s_req   = ifc.imem_req;
    s_addr  = ifc.imem_addr;
    s_valid = ifc.instr_valid;
    s_instr = ifc.instr;
    s_pc    = ifc.instr_pc;

    rv = rsp_pend && (rsp_dly == 0);
    ifc.imem_rvalid = rv;
    ifc.imem_rdata  = rv ? mem_word(rsp_addr) : 16'($urandom);
    s_gnt = s_req && gnt_en && !rsp_pend && (int'($urandom_range(99, 0)) < gnt_pct);
    ifc.imem_gnt    = s_gnt;
    s_rdy = (int'($urandom_range(99, 0)) < rdy_pct);
    ifc.instr_ready = s_rdy;
    ifc.redirect    = drv_redirect;
    ifc.pc_in       = drv_pc;
    rst             = drv_rst;

    if (p_req && !p_gnt && !p_rst) begin
      chk("req_held", s_req, 1'b1);
      chk("req_addr", s_addr, p_redirect ? p_pc_in : p_addr);
    end
    if (s_req && rsp_pend && !rsp_stale)
      chk("one_outstanding", s_req, 1'b0);
    if (s_valid && s_rdy) begin
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_instr", s_instr, mem_word(exp_pc));
      pop_pc_log.push_back(s_pc);
      pop_instr_log.push_back(s_instr);
      exp_pc = exp_pc + 16'd1;
      occ--;
      npop++;
    end
    if (s_gnt) begin
      chk("gnt_addr", s_addr, exp_fetch);
      gnt_addr_log.push_back(s_addr);
      exp_fetch = exp_fetch + 16'd1;
      occ++;
      ngnt++;
      if (!drv_rst && !drv_redirect) chk("credit", occ <= DEPTH, 1'b1);
    end

    @(posedge clk);
    if (rv) rsp_pend = 1'b0;
    if (s_gnt) begin
      rsp_pend  = 1'b1;
      rsp_stale = 1'b0;
      rsp_addr  = s_addr;
      rsp_dly   = int'($urandom_range(dly_max, dly_min));
    end else if (rsp_pend) begin
      rsp_dly--;
    end
    if (drv_rst) begin
      exp_pc    = 16'h0000;
      exp_fetch = 16'h0000;
      occ       = 0;
      if (rsp_pend) rsp_stale = 1'b1;
    end else if (drv_redirect) begin
      exp_pc    = drv_pc;
      exp_fetch = drv_pc;
      occ       = 0;
    end
    p_req      = s_req;
    p_gnt      = s_gnt;
    p_addr     = s_addr;
    p_redirect = drv_redirect;
    p_pc_in    = drv_pc;
    p_rst      = drv_rst;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    cycle();
    cycle();
    drv_rst = 1'b0;
  endtask

  task automatic set_fast();
    gnt_en = 1'b1; gnt_pct = 100; rdy_pct = 100; dly_min = 0; dly_max = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0, n0, first_k;
    bit seen;

    vecs[0] = '{16'h0040, 16'h0040, 16'h0041, 3};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0000, 3};
    vecs[2] = '{16'h1234, 16'h1234, 16'h1235, 3};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h8000, 3};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0001, 3};

    ifc.redirect = 1'b0; ifc.pc_in = '0; ifc.imem_gnt = 1'b0;
    ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0; ifc.instr_ready = 1'b0;
    drv_redirect = 1'b0; drv_pc = '0; drv_rst = 1'b1;
    rsp_pend = 1'b0; rsp_stale = 1'b0; rsp_addr = '0; rsp_dly = 0;
    exp_pc = '0; exp_fetch = '0; occ = 0; npop = 0; ngnt = 0;
    p_req = 1'b0; p_gnt = 1'b0; p_addr = '0; p_redirect = 1'b0; p_pc_in = '0; p_rst = 1'b1;
    set_fast();

    // reset state, then in-order stream 0..3
    do_reset();
    cycle();
    chk("rst_req", s_req, 1'b0);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_instr", s_instr, 16'h0000);
    chk("rst_pc", s_pc, 16'h0000);
    n0 = npop;
    for (int k = 0; k < 40 && npop < n0 + 4; k++) cycle();
    chk("stream_count", npop - n0 >= 4, 1'b1);
    if (npop - n0 >= 4)
      for (int i = 0; i < 4; i++) chk("stream_pc", pop_pc_log[n0 + i], 16'(i));

    // backpressure: only DEPTH reads, head stays stable
    do_reset();
    rdy_pct = 0;
    g0 = ngnt;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_valid) chk("hold_pc", s_pc, 16'h0000);
    end
    chk("reads_issued", ngnt - g0, DEPTH);
    chk("req_idle", s_req, 1'b0);
    chk("head_instr", s_instr, mem_word(16'h0000));
    rdy_pct = 100;
    for (int k = 0; k < 20 && ngnt < g0 + 3; k++) cycle();
    chk("resume_seen", ngnt >= g0 + 3, 1'b1);
    if (ngnt >= g0 + 3) chk("resume_addr", gnt_addr_log[g0 + 2], 16'h0002);

    // redirect table from a parked (full, idle) state
    for (int v = 0; v < 5; v++) begin
      rdy_pct = 0;
      for (int k = 0; k < 12; k++) cycle();
      rdy_pct = 100;
      drv_redirect = 1'b1; drv_pc = vecs[v].target;
      cycle();
      drv_redirect = 1'b0;
      n0 = npop;
      first_k = -1;
      for (int k = 1; k <= 20 && npop < n0 + 2; k++) begin
        cycle();
        if (first_k < 0 && s_valid) first_k = k;
      end
      chk("vec_latency", first_k, vecs[v].exp_lat);
      chk("vec_pops", npop >= n0 + 2, 1'b1);
      if (npop >= n0 + 2) begin
        chk("vec_pc0", pop_pc_log[n0], vecs[v].exp_pc0);
        chk("vec_pc1", pop_pc_log[n0 + 1], vecs[v].exp_pc1);
        chk("vec_instr1", pop_instr_log[n0 + 1], mem_word(vecs[v].exp_pc1));
      end
    end

    // redirect while waiting on a slow read
    do_reset();
    dly_min = 4; dly_max = 4;
    g0 = ngnt;
    for (int k = 0; k < 20 && ngnt == g0; k++) cycle();
    cycle();
    drv_redirect = 1'b1; drv_pc = 16'h0040;
    cycle();
    drv_redirect = 1'b0;
    dly_min = 0; dly_max = 0;
    g0 = ngnt; n0 = npop;
    for (int k = 0; k < 40 && npop == n0; k++) cycle();
    chk("wait_redir_pop", npop > n0, 1'b1);
    if (npop > n0) chk("wait_redir_pc", pop_pc_log[n0], 16'h0040);
    if (ngnt > g0) chk("wait_redir_addr", gnt_addr_log[g0], 16'h0040);

    // grant withheld, redirect mid-request
    do_reset();
    gnt_en = 1'b0;
    for (int k = 0; k < 10 && !s_req; k++) cycle();
    for (int k = 1; k <= 5; k++) begin
      drv_redirect = (k == 3); drv_pc = 16'h0100;
      cycle();
      chk("nogrant_req", s_req, 1'b1);
      chk("nogrant_addr", s_addr, (k <= 3) ? 16'h0000 : 16'h0100);
    end
    drv_redirect = 1'b0;
    gnt_en = 1'b1;
    g0 = ngnt;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      seen = (ngnt > g0);
    end
    chk("nogrant_granted", seen, 1'b1);
    cycle();
    chk("nogrant_single", s_req, 1'b0);

    // reset in the middle of a read
    do_reset();
    dly_min = 3; dly_max = 3;
    g0 = ngnt;
    for (int k = 0; k < 20 && ngnt == g0; k++) cycle();
    cycle();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    dly_min = 0; dly_max = 0;
    cycle();
    chk("midrst_req", s_req, 1'b0);
    chk("midrst_valid", s_valid, 1'b0);
    n0 = npop;
    for (int k = 0; k < 40 && npop == n0; k++) cycle();
    chk("midrst_pop", npop > n0, 1'b1);
    if (npop > n0) chk("midrst_instr", pop_instr_log[n0], mem_word(16'h0000));

    // randomized soak against the scoreboard
    do_reset();
    gnt_pct = 60; rdy_pct = 70; dly_min = 0; dly_max = 3;
    for (int k = 0; k < 3000; k++) begin
      drv_rst      = ($urandom_range(999, 0) < 5);
      drv_redirect = ($urandom_range(99, 0) < 3);
      drv_pc       = ($urandom_range(3, 0) == 0) ? 16'(16'hFFFD + $urandom_range(3, 0))
                                                 : 16'($urandom);
      cycle();
    end
    drv_rst = 1'b0; drv_redirect = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
